// File: rtl/masked_and_sched_pkg.sv
// Shared types and constants for the masked AND gadget scheduler.
package masked_and_sched_pkg;

  localparam int unsigned D       = 2;
  localparam int unsigned RAND_W  = D * (D - 1) / 2;
  localparam int unsigned LAT     = 3;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    IDLE  = 3'd1,
    RAND  = 3'd2,
    RUN   = 3'd3,
    CHECK = 3'd4,
    RESP  = 3'd5
  } state_e;

  // Extract requester idx's shares from a flat [i*D +: D] packed bus.
  function automatic logic [D-1:0] get_share(input logic [MAX_REQ*D-1:0] flat,
                                             input logic [2:0]           idx);
    return flat[32'(idx) * D +: D];
  endfunction

endpackage

// File: rtl/masked_and_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the pointer, pointer advances past the winner on accept.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic               accept,
  output logic [N_REQ-1:0]   gnt_oh_c,
  output logic [IDX_W-1:0]   gnt_idx_c,
  output logic               gnt_any_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  // Scan requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    gnt_oh_c  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!gnt_any_c && req[cand[IDX_W-1:0]]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = cand[IDX_W-1:0];
      end
    end
    if (gnt_any_c) gnt_oh_c[gnt_idx_c] = 1'b1;

    ptr_d = ptr_q;
    if (accept && gnt_any_c) begin
      ptr_d = (gnt_idx_c == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/masked_and_sched.sv
// Shares one 2-share masked AND gadget among N_REQ requesters; keeps the gadget's
// internal step counter aligned after reset or after a missing done.
module masked_and_sched
  import masked_and_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*D-1:0]  req_a,
  input  logic [N_REQ*D-1:0]  req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [D-1:0]        rsp_out,
  output logic                rsp_err,
  input  logic                rand_valid,
  input  logic [RAND_W-1:0]   rand_in,
  output logic                rand_ready,
  output logic [D-1:0]        and_ina,
  output logic [D-1:0]        and_inb,
  output logic [RAND_W-1:0]   and_rin,
  output logic                and_enable,
  input  logic                and_done,
  input  logic [D-1:0]        and_out,
  output logic                busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [D-1:0]       a_q, a_d, b_q, b_d;
  logic [RAND_W-1:0]  r_q, r_d;
  logic [D-1:0]       res_q, res_d;
  logic               err_q, err_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic               sync_en_c;
  logic               accept_c;
  logic [N_REQ-1:0]   gnt_oh_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               gnt_any_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept_c),
    .gnt_oh_c  (gnt_oh_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    res_d       = '0;
    err_d       = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;
    sync_en_c   = 1'b0;
    accept_c    = 1'b0;
    rand_ready  = 1'b0;

    case (state_q)
      // Clock the gadget until a done seen after the first cycle; the first-cycle done may be stale.
      SYNC: begin
        sync_en_c = !(and_done && seen_q);
        seen_d    = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if ((and_done && seen_q) || (cnt_q == CNT_W'(LAT))) begin
          state_d = IDLE;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      IDLE: begin
        if (gnt_any_c) begin
          accept_c    = 1'b1;
          req_ready_d = gnt_oh_c;
          id_d        = gnt_idx_c;
          a_d         = get_share((MAX_REQ*D)'(req_a), 3'(gnt_idx_c));
          b_d         = get_share((MAX_REQ*D)'(req_b), 3'(gnt_idx_c));
          state_d     = RAND;
        end
      end
      RAND: begin
        rand_ready = rand_valid;
        if (rand_valid) begin
          r_d     = rand_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAT - 1)) begin
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      // Gadget output is valid only during this cycle.
      CHECK: begin
        rsp_valid_d = N_REQ'(1) << id_q;
        if (and_done) res_d = and_out;
        else          err_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (err_q) begin
          a_d     = '0;
          b_d     = '0;
          r_d     = '0;
          state_d = SYNC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      res_q       <= res_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_out    = res_q;
  assign rsp_err    = err_q;
  assign and_ina    = a_q;
  assign and_inb    = b_q;
  assign and_rin    = r_q;
  assign and_enable = sync_en_c | (state_q == RUN);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_masked_and_sched.sv
// Bench for masked_and_sched: behavioural gadget model plus directed and randomized operations.
module tb_masked_and_sched;

  localparam int N   = 4;
  localparam int LAT = masked_and_sched_pkg::LAT;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [2*N-1:0] req_a, req_b;
  logic [1:0]   rsp_out, and_ina, and_inb, and_out;
  logic         rsp_err, rand_valid, rand_ready, and_enable, and_done, busy;
  logic [0:0]   rand_in, and_rin;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rr_ptr  = 0;

  // Gadget model controls
  bit         g_preset, g_suppress, g_ovr_en;
  logic [1:0] g_ovr;
  int         g_cnt;
  logic       g_done;
  logic [1:0] g_out;

  masked_and_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_err(rsp_err),
    .rand_valid(rand_valid), .rand_in(rand_in), .rand_ready(rand_ready),
    .and_ina(and_ina), .and_inb(and_inb), .and_rin(and_rin),
    .and_enable(and_enable), .and_done(and_done), .and_out(and_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ISW 2-share AND: shares recombine to (a0^a1)&(b0^b1).
  function automatic logic [1:0] isw(input logic [1:0] a, input logic [1:0] b, input logic r);
    logic z0, z1;
    z0 = (a[0] & b[0]) ^ r;
    z1 = (a[1] & b[1]) ^ ((r ^ (a[0] & b[1])) ^ (a[1] & b[0]));
    return {z1, z0};
  endfunction

  // Gadget: counts enabled cycles mod LAT; done/out registered after the LAT-th, cleared otherwise.
  always @(posedge clk) begin
    if (g_preset) begin
      g_cnt  <= 1;
      g_done <= 1'b1;
      g_out  <= 2'b00;
    end else if (and_enable) begin
      if (g_cnt == LAT - 1) begin
        g_cnt  <= 0;
        g_done <= !g_suppress;
        g_out  <= g_ovr_en ? g_ovr : isw(and_ina, and_inb, and_rin[0]);
      end else begin
        g_cnt  <= g_cnt + 1;
        g_done <= 1'b0;
        g_out  <= 2'b00;
      end
    end else begin
      g_done <= 1'b0;
      g_out  <= 2'b00;
    end
  end
  assign and_done = g_done;
  assign and_out  = g_out;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    logic [N-1:0] seen_rsp;
    k = 0;
    seen_rsp = '0;
    while (busy && k < LAT + 4) begin
      seen_rsp |= rsp_valid;
      tick();
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_no_rsp"}, 32'(seen_rsp), 32'd0);
  endtask

  // One operation from requester id: grant, optional randomness stall, run, check response.
  task automatic do_op(input int id, input logic [1:0] a, input logic [1:0] b,
                       input logic r, input int stall, input bit miss, input string tag);
    int k, t_g;
    logic [1:0] exp_out;
    req_a[id*2 +: 2] = a;
    req_b[id*2 +: 2] = b;
    req_valid  = onehot(id);
    rand_valid = 1'b0;
    g_suppress = miss;
    k = 0;
    while (req_ready == '0 && k < 20) begin tick(); k++; end
    chk({tag, "_grant"}, 32'(req_ready), 32'(onehot(id)));
    rr_ptr    = (id + 1) % N;
    t_g       = cyc;
    req_valid = '0;
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_rdy"}, 32'(rand_ready), 32'd0);
      chk({tag, "_stall_en"}, 32'(and_enable), 32'd0);
      tick();
    end
    rand_valid = 1'b1;
    rand_in[0] = r;
    #1;
    chk({tag, "_rand_rdy"}, 32'(rand_ready), 32'd1);
    tick();
    rand_valid = 1'b0;
    chk({tag, "_run_en"}, 32'(and_enable), 32'd1);
    chk({tag, "_rin"}, 32'(and_rin), 32'(r));
    chk({tag, "_ina"}, 32'(and_ina), 32'(a));
    chk({tag, "_inb"}, 32'(and_inb), 32'(b));
    k = 0;
    while (rsp_valid == '0 && k < 12) begin tick(); k++; end
    exp_out = miss ? 2'b00 : (g_ovr_en ? g_ovr : isw(a, b, r));
    chk({tag, "_rsp_id"}, 32'(rsp_valid), 32'(onehot(id)));
    chk({tag, "_lat"}, 32'(cyc - t_g), 32'(stall + 5));
    chk({tag, "_rsp_out"}, 32'(rsp_out), 32'(exp_out));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(miss));
    chk({tag, "_no_rdy"}, 32'(req_ready), 32'd0);
    g_suppress = 1'b0;
    tick();
    if (miss) begin
      chk({tag, "_sync_busy"}, 32'(busy), 32'd1);
      chk({tag, "_sync_en"}, 32'(and_enable), 32'd1);
      wait_idle({tag, "_resync"});
    end else begin
      chk({tag, "_back_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w, t_prev;
    logic [1:0] fa [N];
    logic [1:0] fb [N];
    logic [1:0] ra, rb;

    rst = 1'b1; g_preset = 1'b1; g_suppress = 1'b0; g_ovr_en = 1'b0; g_ovr = 2'b00;
    req_valid = '0; req_a = '0; req_b = '0; rand_valid = 1'b0; rand_in = '0;
    t_prev = 0;
    tick(); tick();
    rst = 1'b0; g_preset = 1'b0;

    // Post-reset sync: gadget counter at 1 with a stale done
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ops", 32'({and_ina, and_inb, and_rin}), 32'd0);
    chk("rst_rand_ready", 32'(rand_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("sync_ignore_stale", 32'(and_enable), 32'd1);
    tick();
    chk("sync_c2_en", 32'(and_enable), 32'd1);
    tick();
    chk("sync_fresh_done", 32'(and_done), 32'd1);
    chk("sync_drop_en", 32'(and_enable), 32'd0);
    tick();
    chk("sync_idle", 32'(busy), 32'd0);
    chk("sync_no_rsp", 32'(rsp_valid), 32'd0);

    // Single op with a forced gadget result
    g_ovr_en = 1'b1; g_ovr = 2'b01;
    do_op(0, 2'b10, 2'b11, 1'b1, 0, 1'b0, "single");
    g_ovr_en = 1'b0;

    // Randomness stall
    do_op(2, 2'b01, 2'b11, 1'b1, 5, 1'b0, "stall");

    // Missing done, then a good op from the same requester
    do_op(1, 2'b11, 2'b11, 1'b0, 0, 1'b1, "miss");
    do_op(1, 2'b10, 2'b01, 1'b1, 0, 1'b0, "after_miss");

    // Round-robin with all requesters held
    rand_valid = 1'b1;
    rand_in    = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      fa[i] = 2'($urandom);
      fb[i] = 2'($urandom);
      req_a[i*2 +: 2] = fa[i];
      req_b[i*2 +: 2] = fb[i];
    end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      k = 0;
      while (req_ready == '0 && k < 16) begin tick(); k++; end
      w = rr_pick(req_valid, rr_ptr);
      chk("rr_grant", 32'(req_ready), 32'(onehot(w)));
      if (n > 0) chk("rr_period", 32'(cyc - t_prev), 32'd7);
      t_prev = cyc;
      rr_ptr = (w + 1) % N;
      tick();
      k = 0;
      while (rsp_valid == '0 && k < 12) begin tick(); k++; end
      chk("rr_rsp_id", 32'(rsp_valid), 32'(onehot(w)));
      chk("rr_rsp_out", 32'(rsp_out), 32'(isw(fa[w], fb[w], rand_in[0])));
      chk("rr_no_rdy", 32'(req_ready), 32'd0);
      if (n == 4) req_valid = '0;
    end
    rand_valid = 1'b0;
    tick();
    chk("rr_done_idle", 32'(busy), 32'd0);

    // Reset on the 2nd RUN cycle
    req_a[3*2 +: 2] = 2'b01;
    req_b[3*2 +: 2] = 2'b10;
    req_valid = onehot(3);
    k = 0;
    while (req_ready == '0 && k < 20) begin tick(); k++; end
    chk("rst_run_grant", 32'(req_ready), 32'(onehot(3)));
    req_valid  = '0;
    rand_valid = 1'b1;
    rand_in    = 1'b1;
    tick();
    rand_valid = 1'b0;
    chk("rst_run_c1_en", 32'(and_enable), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outs", 32'({req_ready, rsp_valid, rsp_out, rsp_err, rand_ready}), 32'd0);
    chk("midrst_ops", 32'({and_ina, and_inb, and_rin}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    wait_idle("midrst");
    rr_ptr = 0;
    do_op(3, 2'b01, 2'b10, 1'b1, 0, 1'b0, "resubmit");

    // Randomized single-requester operations
    for (int i = 0; i < 8; i++) begin
      w  = int'($urandom_range(N - 1, 0));
      ra = 2'($urandom);
      rb = 2'($urandom);
      do_op(w, ra, rb, 1'($urandom), int'($urandom_range(3, 0)), 1'b0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
